dcache_tag_ctrl: RTL

//  Initiator side of the dcache tag RAM: owns the RAM port (req/wr_en/addr/wdata/rdata).

---
 rtl/dcache_tag_ctrl_pkg.sv | 39 +++
 rtl/dcache_tag_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_ctrl_pkg.sv
// rtl/dcache_tag_ctrl_pkg.sv - shared types and geometry for the dcache tag controller
//
// Purpose: op encoding, controller state encoding, default cache geometry and the
// tag entry layout for the default 32-bit entry.
package dcache_tag_ctrl_pkg;

    localparam int DCACHE_NO_OF_SETS = 12;
    localparam int DCACHE_DW         = 32;
    localparam int DCACHE_TAG_BITS   = 20;

    // Bit positions of the status flags inside a default-width entry.
    localparam int VALID_BIT = DCACHE_DW - 1;
    localparam int DIRTY_BIT = DCACHE_DW - 2;

    typedef enum logic [1:0] {
        TAG_LOOKUP    = 2'd0,
        TAG_FILL      = 2'd1,
        TAG_SET_DIRTY = 2'd2,
        TAG_INVAL     = 2'd3
    } tag_op_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP,
        ST_FL_RD,
        ST_FL_CHK,
        ST_FL_WB,
        ST_FL_INV
    } tag_state_e;

    typedef struct packed {
        logic                                    valid;
        logic                                    dirty;
        logic [DCACHE_DW-DCACHE_TAG_BITS-3:0]    pad;
        logic [DCACHE_TAG_BITS-1:0]              tag;
    } tag_entry_t;

endpackage

// File: rtl/dcache_tag_ctrl.sv
// rtl/dcache_tag_ctrl.sv - tag RAM port owner: op handshake, post-reset invalidate, flush sweep
//
// Purpose: serves LOOKUP/FILL/SET_DIRTY/INVAL ops (one op per two cycles, response one
// cycle after accept), clears every set after reset, and sweeps all sets on flush
// handing dirty victims to the writeback path before invalidating them.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready/req_op/req_set/req_tag   op request handshake
//   rsp_valid/rsp_hit/rsp_dirty/rsp_tag          one-cycle op response
//   flush_req/flush_done           flush sweep start level / end strobe
//   wb_valid/wb_ready/wb_set/wb_tag              dirty victim handshake
//   init_done                      high once the post-reset sweep has finished
//   ram_req/ram_wr_en/ram_addr/ram_wdata/ram_rdata  tag RAM port (1-cycle read latency)
module dcache_tag_ctrl
    import dcache_tag_ctrl_pkg::*;
#(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int NO_OF_SETS = DCACHE_NO_OF_SETS,
    parameter int ADDR_WIDTH = $clog2(NO_OF_SETS),
    parameter int TAG_BITS   = 20
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_op,
    input  logic [ADDR_WIDTH-1:0]          req_set,
    input  logic [TAG_BITS-1:0]            req_tag,
    output logic                           rsp_valid,
    output logic                           rsp_hit,
    output logic                           rsp_dirty,
    output logic [TAG_BITS-1:0]            rsp_tag,
    input  logic                           flush_req,
    output logic                           flush_done,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [ADDR_WIDTH-1:0]          wb_set,
    output logic [TAG_BITS-1:0]            wb_tag,
    output logic                           init_done,
    output logic                           ram_req,
    output logic [NUM_COL-1:0]             ram_wr_en,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [NUM_COL*COL_WIDTH-1:0]   ram_wdata,
    input  logic [NUM_COL*COL_WIDTH-1:0]   ram_rdata
);

    localparam int                    DW       = NUM_COL * COL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_SET = ADDR_WIDTH'(NO_OF_SETS - 1);
    // The valid/dirty flags live in the top column, so clearing only that column
    // invalidates an entry without touching its tag.
    localparam logic [NUM_COL-1:0]    TOP_COL  = {1'b1, {(NUM_COL-1){1'b0}}};
    localparam logic [NUM_COL-1:0]    ALL_COL  = '1;

    function automatic logic [DW-1:0] make_entry(input logic dirty, input logic [TAG_BITS-1:0] tag);
        logic [DW-1:0] e;
        e                 = '0;
        e[DW-1]           = 1'b1;
        e[DW-2]           = dirty;
        e[TAG_BITS-1:0]   = tag;
        return e;
    endfunction

    tag_state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0]     set_cnt, set_cnt_nxt;
    logic                      init_done_q, init_done_nxt;
    tag_op_e                   op_q;
    logic [TAG_BITS-1:0]       tag_q;
    logic [TAG_BITS-1:0]       victim_tag_q;
    logic                      accept;
    logic                      next_set;
    tag_op_e                   op_in;
    logic                      rd_valid;
    logic                      rd_dirty;
    logic [TAG_BITS-1:0]       rd_tag;
    logic                      last_set;
    logic                      unused_rdata;

    assign op_in        = tag_op_e'(req_op);
    assign rd_valid     = ram_rdata[DW-1];
    assign rd_dirty     = ram_rdata[DW-2];
    assign rd_tag       = ram_rdata[TAG_BITS-1:0];
    assign last_set     = (set_cnt == LAST_SET);
    assign init_done    = init_done_q;
    assign unused_rdata = ^ram_rdata[DW-3:TAG_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT;
            set_cnt      <= '0;
            init_done_q  <= 1'b0;
            op_q         <= TAG_LOOKUP;
            tag_q        <= '0;
            victim_tag_q <= '0;
        end else begin
            state       <= state_nxt;
            set_cnt     <= set_cnt_nxt;
            init_done_q <= init_done_nxt;
            if (accept) begin
                op_q  <= op_in;
                tag_q <= req_tag;
            end
            // Hold the victim tag ourselves: rdata is only guaranteed for one cycle
            // and the writeback path may stall for many.
            if (state == ST_FL_CHK) begin
                victim_tag_q <= rd_tag;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        set_cnt_nxt   = set_cnt;
        init_done_nxt = init_done_q;
        accept        = 1'b0;
        next_set      = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_hit       = 1'b0;
        rsp_dirty     = 1'b0;
        rsp_tag       = '0;
        flush_done    = 1'b0;
        wb_valid      = 1'b0;
        wb_set        = '0;
        wb_tag        = '0;
        ram_req       = 1'b0;
        ram_wr_en     = '0;
        ram_addr      = '0;
        ram_wdata     = '0;

        case (state)
            ST_INIT: begin
                ram_req   = 1'b1;
                ram_wr_en = TOP_COL;
                ram_addr  = set_cnt;
                if (last_set) begin
                    state_nxt     = ST_IDLE;
                    set_cnt_nxt   = '0;
                    init_done_nxt = 1'b1;
                end else begin
                    set_cnt_nxt = set_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                req_ready = !flush_req;
                if (flush_req) begin
                    state_nxt   = ST_FL_RD;
                    set_cnt_nxt = '0;
                end else if (req_valid) begin
                    accept    = 1'b1;
                    ram_req   = 1'b1;
                    ram_addr  = req_set;
                    state_nxt = ST_RESP;
                    case (op_in)
                        TAG_FILL: begin
                            ram_wr_en = ALL_COL;
                            ram_wdata = make_entry(1'b0, req_tag);
                        end
                        TAG_SET_DIRTY: begin
                            ram_wr_en = ALL_COL;
                            ram_wdata = make_entry(1'b1, req_tag);
                        end
                        TAG_INVAL: begin
                            ram_wr_en = TOP_COL;
                        end
                        default: begin
                            ram_wr_en = '0;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (op_q == TAG_LOOKUP) begin
                    rsp_hit   = rd_valid && (rd_tag == tag_q);
                    rsp_dirty = rd_dirty;
                    rsp_tag   = rd_tag;
                end
                state_nxt = ST_IDLE;
            end
            ST_FL_RD: begin
                ram_req   = 1'b1;
                ram_addr  = set_cnt;
                state_nxt = ST_FL_CHK;
            end
            ST_FL_CHK: begin
                if (rd_valid && rd_dirty) begin
                    state_nxt = ST_FL_WB;
                end else if (rd_valid) begin
                    state_nxt = ST_FL_INV;
                end else begin
                    next_set = 1'b1;
                end
            end
            ST_FL_WB: begin
                wb_valid = 1'b1;
                wb_set   = set_cnt;
                wb_tag   = victim_tag_q;
                if (wb_ready) begin
                    state_nxt = ST_FL_INV;
                end
            end
            ST_FL_INV: begin
                ram_req   = 1'b1;
                ram_wr_en = TOP_COL;
                ram_addr  = set_cnt;
                next_set  = 1'b1;
            end
            default: begin
                state_nxt   = ST_INIT;
                set_cnt_nxt = '0;
            end
        endcase

        // Terminal test on the last real set index, so a non-power-of-two set
        // count never relies on counter overflow.
        if (next_set) begin
            if (last_set) begin
                flush_done  = 1'b1;
                state_nxt   = ST_IDLE;
                set_cnt_nxt = '0;
            end else begin
                set_cnt_nxt = set_cnt + ADDR_WIDTH'(1);
                state_nxt   = ST_FL_RD;
            end
        end

        // The state register sits in INIT while reset is held; keep the RAM port
        // quiet until reset is actually released.
        if (rst) begin
            ram_req   = 1'b0;
            ram_wr_en = '0;
            ram_addr  = '0;
        end
    end

endmodule
